// File: rtl/hps_dma_bridge_if.sv
// hps_dma_bridge_if: HPS disk-DMA word port plus Avalon-MM master bus and error flags
interface hps_dma_bridge_if;
  logic        dma_rd;
  logic        dma_wr;
  logic [31:0] dma_addr;
  logic [31:0] dma_dout;
  logic [31:0] dma_din;
  logic        ioctl_wait;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        err_timeout;
  logic        err_overflow;
  modport master (
    input  dma_rd, dma_wr, dma_addr, dma_dout, mem_waitrequest, mem_readdata, mem_readdatavalid,
    output dma_din, ioctl_wait, mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    output err_timeout, err_overflow
  );
  modport slave (
    output dma_rd, dma_wr, dma_addr, dma_dout, mem_waitrequest, mem_readdata, mem_readdatavalid,
    input  dma_din, ioctl_wait, mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
    input  err_timeout, err_overflow
  );
endinterface

// File: rtl/hps_dma_bridge.sv
// hps_dma_bridge: HPS disk-DMA words onto Avalon-MM with posted writes and ordered, time-limited reads
module hps_dma_bridge #(
  parameter int WFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 65535
) (
  input  logic clk_sys,
  input  logic reset,
  hps_dma_bridge_if.master bus
);
  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL  = (AW+1)'(WFIFO_DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, DRAIN, REQ, DATA} state_t;
  state_t        r_st;
  logic [31:0]   r_fa [WFIFO_DEPTH];
  logic [31:0]   r_fd [WFIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_raddr, r_din, r_addr, r_wdata;
  logic          r_wait, r_mw, r_mr, r_etmo, r_eovf;
  logic          w_full, w_push, w_acc, w_bypass, w_load, w_rd_go, w_req_go, w_tmo, w_rd_done, w_busy_n;
  logic [AW-1:0] w_hidx;
  logic [AW:0]   w_cnt_n;
  assign w_full    = r_cnt == FULL;
  assign w_push    = bus.dma_wr & ~w_full;
  assign w_acc     = r_mw & ~bus.mem_waitrequest;
  assign w_hidx    = w_acc ? r_rp + AW'(1) : r_rp;
  // no stored entry behind the head: the word being pushed right now is the next one out
  assign w_bypass  = w_acc ? r_cnt == (AW+1)'(1) : r_cnt == '0;
  assign w_rd_go   = r_st == IDLE & bus.dma_rd & ~w_full;
  assign w_req_go  = r_st == DRAIN & r_cnt == '0 & ~r_mw;
  assign w_load    = (~r_mw | w_acc) & (~w_bypass | w_push) & r_st != REQ & ~w_req_go;
  assign w_tmo     = r_tmo == TLAST;
  assign w_rd_done = (r_st == DATA & (bus.mem_readdatavalid | w_tmo)) | (r_st == REQ & w_tmo);
  assign w_busy_n  = (r_st != IDLE & ~w_rd_done) | w_rd_go;
  assign w_cnt_n   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_acc);
  always_ff @(posedge clk_sys)
    if (w_push) begin
      r_fa[r_wp] <= bus.dma_addr;
      r_fd[r_wp] <= bus.dma_dout;
    end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_st    <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_raddr <= '0;
      r_din   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wait  <= 1'b0;
      r_mw    <= 1'b0;
      r_mr    <= 1'b0;
      r_etmo  <= 1'b0;
      r_eovf  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_n;
      r_wait <= w_cnt_n == FULL | w_busy_n;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_acc) r_rp <= r_rp + AW'(1);
      if ((bus.dma_wr & w_full) | (bus.dma_rd & (r_st != IDLE | w_full))) r_eovf <= 1'b1;
      if (w_load) begin
        r_mw    <= 1'b1;
        r_addr  <= w_bypass ? bus.dma_addr : r_fa[w_hidx];
        r_wdata <= w_bypass ? bus.dma_dout : r_fd[w_hidx];
      end else if (w_acc) r_mw <= 1'b0;
      case (r_st)
        IDLE: if (w_rd_go) begin
          r_raddr <= bus.dma_addr;
          r_st    <= DRAIN;
        end
        DRAIN: if (w_req_go) begin
          r_st   <= REQ;
          r_mr   <= 1'b1;
          r_addr <= r_raddr;
          r_tmo  <= '0;
        end
        REQ: begin
          r_tmo <= r_tmo + TW'(1);
          if (w_tmo) begin
            r_mr   <= 1'b0;
            r_din  <= '1;
            r_etmo <= 1'b1;
            r_st   <= IDLE;
          end else if (~bus.mem_waitrequest) begin
            r_mr <= 1'b0;
            r_st <= DATA;
          end
        end
        default: begin
          r_tmo <= r_tmo + TW'(1);
          if (bus.mem_readdatavalid) begin
            r_din <= bus.mem_readdata;
            r_st  <= IDLE;
          end else if (w_tmo) begin
            r_din  <= '1;
            r_etmo <= 1'b1;
            r_st   <= IDLE;
          end
        end
      endcase
    end
  end
  assign bus.dma_din        = r_din;
  assign bus.ioctl_wait     = r_wait;
  assign bus.mem_address    = r_addr;
  assign bus.mem_read       = r_mr;
  assign bus.mem_write      = r_mw;
  assign bus.mem_writedata  = r_wdata;
  assign bus.mem_byteenable = 4'hF;
  assign bus.err_timeout    = r_etmo;
  assign bus.err_overflow   = r_eovf;
endmodule

// File: tb/tb_hps_dma_bridge.sv
// tb_hps_dma_bridge: directed and randomized checks of hps_dma_bridge against a memory/queue model
module tb_hps_dma_bridge;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hps_dma_bridge_if bus();
  hps_dma_bridge #(.WFIFO_DEPTH(4), .TIMEOUT(TMO)) dut (.clk_sys(clk), .reset(rst), .bus(bus));
  int errs = 0;
  int checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  logic [31:0] mem [bit [31:0]];
  logic [31:0] model [bit [31:0]];
  logic [31:0] wlog_a[$], wlog_d[$], exp_a[$], exp_d[$];
  int acc_cnt = 0;
  int pushes = 0;
  int both = 0;
  int rd_cd = 0;
  int wr_rate = 0;
  bit acc_now = 0;
  bit hold_wr = 0;
  bit mute = 0;
  bit stray = 0;
  logic [31:0] rd_q;
  // Avalon slave: all decisions for the coming rising edge are made at the falling edge
  initial begin
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_readdata = '0;
    forever begin
      @(negedge clk);
      acc_now = 0;
      bus.mem_readdatavalid = 1'b0;
      bus.mem_waitrequest = hold_wr || ($urandom_range(99) < wr_rate);
      if (!rst) begin
        if (bus.mem_read && bus.mem_write) both++;
        if (rd_cd > 0) begin
          rd_cd--;
          if (rd_cd == 0 && !mute) begin
            bus.mem_readdatavalid = 1'b1;
            bus.mem_readdata = rd_q;
          end
        end
        if (stray) begin
          bus.mem_readdatavalid = 1'b1;
          bus.mem_readdata = 32'h5A5A_5A5A;
          stray = 0;
        end
        if (!bus.mem_waitrequest && bus.mem_write) begin
          mem[bus.mem_address] = bus.mem_writedata;
          wlog_a.push_back(bus.mem_address);
          wlog_d.push_back(bus.mem_writedata);
          acc_cnt++;
          acc_now = 1;
        end
        if (!bus.mem_waitrequest && bus.mem_read) begin
          rd_q = mem.exists(bus.mem_address) ? mem[bus.mem_address] : 32'h0;
          rd_cd = $urandom_range(3, 1);
          check("rd_after_wr", acc_cnt, pushes);
        end
      end
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int c = pushes - (acc_cnt - int'(acc_now));
    bus.dma_rd = rd;
    bus.dma_wr = wr;
    bus.dma_addr = a;
    bus.dma_dout = d;
    if (wr && c < 4) begin
      pushes++;
      exp_a.push_back(a);
      exp_d.push_back(d);
      model[a] = d;
    end
    tick();
    bus.dma_rd = 1'b0;
    bus.dma_wr = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done"}, bus.ioctl_wait, 0);
  endtask
  task automatic do_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    do_req(1, 0, a, 0);
    check({tag, "_wait"}, bus.ioctl_wait, 1);
    wait_idle(tag);
    check({tag, "_din"}, bus.dma_din, exp);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"}, bus.dma_din, 0);
    check({tag, "_wait"}, bus.ioctl_wait, 0);
    check({tag, "_mrd"}, bus.mem_read, 0);
    check({tag, "_mwr"}, bus.mem_write, 0);
    check({tag, "_addr"}, bus.mem_address, 0);
    check({tag, "_wdata"}, bus.mem_writedata, 0);
    check({tag, "_etmo"}, bus.err_timeout, 0);
    check({tag, "_eovf"}, bus.err_overflow, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int base, n;
    logic [31:0] a, v;
    bus.dma_rd = 1'b0;
    bus.dma_wr = 1'b0;
    bus.dma_addr = '0;
    bus.dma_dout = '0;
    tick();
    tick();
    check_reset_outputs("rst0");
    check("byteen", bus.mem_byteenable, 4'hF);
    rst = 1'b0;
    tick();
    do_req(0, 1, 32'h100, 32'hDEAD_BEEF);
    check("w1_mwr", bus.mem_write, 1);
    check("w1_addr", bus.mem_address, 32'h100);
    check("w1_data", bus.mem_writedata, 32'hDEAD_BEEF);
    check("w1_wait", bus.ioctl_wait, 0);
    tick();
    check("w1_mwr_drop", bus.mem_write, 0);
    hold_wr = 1;
    base = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1, 32'h180 + 4 * i, 32'hA000 + i);
      check($sformatf("bp_wait%0d", i), bus.ioctl_wait, i == 3);
    end
    do_req(0, 1, 32'h1F0, 32'hBAD);
    check("bp_ovf", bus.err_overflow, 1);
    check("bp_still_wait", bus.ioctl_wait, 1);
    hold_wr = 0;
    tick();
    check("bp_pre_pop", bus.ioctl_wait, 1);
    tick();
    check("bp_after_pop", bus.ioctl_wait, 0);
    tick();
    tick();
    check("bp_b2b", acc_cnt - base, 4);
    repeat (3) tick();
    hold_wr = 1;
    do_req(0, 1, 32'h200, 32'h11);
    do_req(0, 1, 32'h204, 32'h22);
    do_req(1, 0, 32'h204, 0);
    check("ord_wait", bus.ioctl_wait, 1);
    repeat (2) tick();
    hold_wr = 0;
    wait_idle("ord");
    check("ord_din", bus.dma_din, 32'h22);
    v = $urandom;
    do_req(1, 1, 32'h300, v);
    check("sim_wait", bus.ioctl_wait, 1);
    wait_idle("sim");
    check("sim_din", bus.dma_din, v);
    wr_rate = 30;
    for (int i = 0; i < 150; i++) begin
      n = 0;
      while (bus.ioctl_wait && n < 100) begin
        tick();
        n++;
      end
      if (bus.ioctl_wait) check("rnd_stall", bus.ioctl_wait, 0);
      a = 32'h400 + 4 * $urandom_range(7);
      if ($urandom_range(2) == 0) do_rd(a, model.exists(a) ? model[a] : 32'h0, "rnd");
      else do_req(0, 1, a, $urandom);
      if ($urandom_range(3) == 0) tick();
    end
    wr_rate = 0;
    repeat (10) tick();
    check("pre_tmo_etmo", bus.err_timeout, 0);
    mute = 1;
    do_req(1, 0, 32'h400, 0);
    n = 1;
    while (bus.ioctl_wait && n < 100) begin
      tick();
      n++;
    end
    check("tmo_len", n >= TMO && n <= TMO + 4, 1);
    check("tmo_din", bus.dma_din, 32'hFFFF_FFFF);
    check("tmo_etmo", bus.err_timeout, 1);
    check("tmo_wait", bus.ioctl_wait, 0);
    stray = 1;
    repeat (3) tick();
    check("tmo_stray", bus.dma_din, 32'hFFFF_FFFF);
    do_req(1, 0, 32'h200, 0);
    repeat (3) tick();
    check("rr_busy", bus.ioctl_wait, 1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rr");
    rd_cd = 0;
    tick();
    rst = 1'b0;
    mute = 0;
    tick();
    hold_wr = 1;
    do_req(0, 1, 32'h600, 32'h1);
    do_req(0, 1, 32'h604, 32'h2);
    check("rw_busy", bus.mem_write, 1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rw");
    tick();
    rst = 1'b0;
    hold_wr = 0;
    pushes = acc_cnt;
    while (exp_a.size() > wlog_a.size()) begin
      void'(exp_a.pop_back());
      void'(exp_d.pop_back());
    end
    tick();
    do_req(0, 1, 32'h500, 32'hCAFE_F00D);
    check("post_mwr", bus.mem_write, 1);
    check("post_addr", bus.mem_address, 32'h500);
    check("post_wait", bus.ioctl_wait, 0);
    repeat (3) tick();
    check("excl", both, 0);
    check("wlog_n", wlog_a.size(), exp_a.size());
    for (int i = 0; i < wlog_a.size() && i < exp_a.size(); i++) begin
      check($sformatf("wlog_a%0d", i), wlog_a[i], exp_a[i]);
      check($sformatf("wlog_d%0d", i), wlog_d[i], exp_d[i]);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
